bcd_tick_counter: RTL

//   Prescaled 3-digit BCD counter (000-999) sitting directly upstream of the 7-segment decoders.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_tick_counter_if.sv | 28 ++
 rtl/bcd_digit.sv | 54 +++++
 rtl/bcd_tick_counter.sv | 102 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and prescaler width helper for the tick counter.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX  = 4'd9;
   localparam bcd_t BCD_ZERO = 4'd0;

   function automatic int unsigned div_width(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
      return $clog2(clk_hz / tick_hz);
   endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control and display bundle of the BCD tick counter; up_dn exists only with BCD_DIR_EN.
interface bcd_tick_counter_if;
   import bcd_pkg::*;

   logic run_en;
   logic clear;
`ifdef BCD_DIR_EN
   logic up_dn;
`endif
   bcd_t digit0;
   bcd_t digit1;
   bcd_t digit2;
   logic tick;
   logic wrap;

`ifdef BCD_DIR_EN
   modport master (output run_en, clear, up_dn,
                   input  digit0, digit1, digit2, tick, wrap);
   modport slave  (input  run_en, clear, up_dn,
                   output digit0, digit1, digit2, tick, wrap);
`else
   modport master (output run_en, clear,
                   input  digit0, digit1, digit2, tick, wrap);
   modport slave  (input  run_en, clear,
                   output digit0, digit1, digit2, tick, wrap);
`endif

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register with ripple carry (and borrow when BCD_DIR_EN is defined).
module bcd_digit
   import bcd_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic carry_i,
`ifdef BCD_DIR_EN
   input  logic dn_i,
`endif
   output bcd_t digit_o,
   output logic carry_c
);

   bcd_t digit_q;
   bcd_t digit_d;
   logic dn;

`ifdef BCD_DIR_EN
   assign dn = dn_i;
`else
   assign dn = 1'b0;
`endif

   // Out-of-range codes behave as 9 in both directions.
   always_comb begin
      digit_d = digit_q;
      carry_c = 1'b0;
      if (carry_i) begin
         if (dn) begin
            carry_c = (digit_q == BCD_ZERO);
            if (digit_q == BCD_ZERO)
               digit_d = BCD_MAX;
            else if (digit_q > BCD_MAX)
               digit_d = BCD_MAX - 4'd1;
            else
               digit_d = digit_q - 4'd1;
         end else begin
            carry_c = (digit_q >= BCD_MAX);
            digit_d = (digit_q >= BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        digit_q <= BCD_ZERO;
      else if (clear_i) digit_q <= BCD_ZERO;
      else              digit_q <= digit_d;
   end

   assign digit_o = digit_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled 3-digit BCD counter feeding the 7-segment decoders.
// Optional down counting via macro BCD_DIR_EN (adds up_dn to the interface).
module bcd_tick_counter
   import bcd_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic                CLK_50,
   input  logic                RST,
   bcd_tick_counter_if.slave   bus
);

   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned PRESC_W = div_width(CLK_HZ, TICK_HZ);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] presc_d;
   logic               tick_q;
   logic               tick_d;
   logic               wrap_q;
   logic               wrap_d;
   logic               event_c;
   logic               carry0_c;
   logic               carry1_c;
   logic               carry2_c;
   bcd_t               digit0;
   bcd_t               digit1;
   bcd_t               digit2;

   assign event_c = bus.run_en && (presc_q == PRESC_LAST);

   // Prescaler holds while disabled; clear wins over a coincident count event.
   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (bus.clear) begin
         presc_d = '0;
      end else if (bus.run_en) begin
         presc_d = event_c ? '0 : presc_q + PRESC_W'(1);
         tick_d  = event_c;
         wrap_d  = event_c && carry2_c;
      end
   end

   always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   bcd_digit u_digit0 (
      .clk_i   (CLK_50),
      .rst_i   (RST),
      .clear_i (bus.clear),
      .carry_i (event_c),
`ifdef BCD_DIR_EN
      .dn_i    (~bus.up_dn),
`endif
      .digit_o (digit0),
      .carry_c (carry0_c)
   );

   bcd_digit u_digit1 (
      .clk_i   (CLK_50),
      .rst_i   (RST),
      .clear_i (bus.clear),
      .carry_i (carry0_c),
`ifdef BCD_DIR_EN
      .dn_i    (~bus.up_dn),
`endif
      .digit_o (digit1),
      .carry_c (carry1_c)
   );

   bcd_digit u_digit2 (
      .clk_i   (CLK_50),
      .rst_i   (RST),
      .clear_i (bus.clear),
      .carry_i (carry1_c),
`ifdef BCD_DIR_EN
      .dn_i    (~bus.up_dn),
`endif
      .digit_o (digit2),
      .carry_c (carry2_c)
   );

   assign bus.digit0 = digit0;
   assign bus.digit1 = digit1;
   assign bus.digit2 = digit2;
   assign bus.tick   = tick_q;
   assign bus.wrap   = wrap_q;

endmodule
